// File: rtl/sbus_bridge.sv
// Single-outstanding bridge from the pipeline's sbus port to a split address/data downstream handshake.
// Optional feature: define SBUS_BRIDGE_ALIGN_CHECK_EN to trap misaligned half/word accesses instead of forwarding them.
module sbus_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_w,
   input  logic              update,
   output logic [DATA_W-1:0] data_r,
   output logic              stall,
   output logic              req,
   output logic              wr,
   output logic [1:0]        req_size,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [DATA_W-1:0] rdata,
   output logic              misalign
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] data_r_q, data_r_d;
   logic              req_q, req_d;
   logic              misalign_q, misalign_d;
   logic              capture_s;

`ifdef SBUS_BRIDGE_ALIGN_CHECK_EN
   // Size 11 is undefined and passes through unchecked.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
      logic bad;
      case (sz)
         2'b10:   bad = (a_lo != 2'b00);
         2'b01:   bad = a_lo[0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction
`endif

   // Next-state, request capture and read-data latch.
   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      data_r_d   = data_r_q;
      misalign_d = 1'b0;
      capture_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               capture_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (addr_ok && data_ok) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  data_r_d = rdata;
               end else begin
                  data_r_d = data_r_q;
               end
            end else if (addr_ok) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (data_ok) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  data_r_d = rdata;
               end else begin
                  data_r_d = data_r_q;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DONE: begin
            if (update && en) begin
               capture_s = 1'b1;
            end else if (update) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_DONE;
               misalign_d = misalign_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A capture always loads the request registers; only the routing depends on alignment.
      if (capture_s) begin
         wr_d    = we;
         size_d  = size;
         addr_d  = addr;
         wdata_d = data_w;
`ifdef SBUS_BRIDGE_ALIGN_CHECK_EN
         if (is_misaligned(size, addr[1:0])) begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
         end else begin
            state_d    = ST_ADDR;
            misalign_d = 1'b0;
         end
`else
         state_d = ST_ADDR;
`endif
      end else begin
         wr_d = wr_q;
      end
   end

   assign req_d = (state_d == ST_ADDR);

   // State and request register bank.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_q       <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= {ADDR_W{1'b0}};
         wdata_q    <= {DATA_W{1'b0}};
         data_r_q   <= {DATA_W{1'b0}};
         req_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         data_r_q   <= data_r_d;
         req_q      <= req_d;
         misalign_q <= misalign_d;
      end
   end

   // Stall must react to en in the same cycle; gated by reset so it drops immediately.
   assign stall = rst & (((state_q == ST_IDLE) & en) | (state_q == ST_ADDR) | (state_q == ST_DATA));

   assign data_r    = data_r_q;
   assign req       = req_q;
   assign wr        = wr_q;
   assign req_size  = size_q;
   assign req_addr  = addr_q;
   assign req_wdata = wdata_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_sbus_bridge.sv
// Directed bench for sbus_bridge: reset, fast/split reads, back-to-back write/read, mid-access reset, alignment, hold.
module tb_sbus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, we, update, addr_ok, data_ok;
   logic [1:0]  size;
   logic [31:0] addr, data_w, rdata;
   logic [31:0] data_r, req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        stall, req, wr, misalign;

   int n_cmp = 0;
   int n_err = 0;

   sbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .size(size), .addr(addr),
      .data_w(data_w), .update(update), .data_r(data_r), .stall(stall),
      .req(req), .wr(wr), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .addr_ok(addr_ok), .data_ok(data_ok),
      .rdata(rdata), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; registered outputs are settled 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      en = 1'b0; we = 1'b0; size = 2'b00; addr = 32'h0; data_w = 32'h0;
      update = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      en = 1'b1;
      repeat (2) tick();
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_data_r", data_r, 32'h0);
      chk("rst_req_addr", req_addr, 32'h0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      idle_inputs();
      rst = 1'b1;

      // Minimum-latency word read
      tick();
      en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_1000;
      #1;
      chk("rd_stall_n", {31'd0, stall}, 32'd1);
      chk("rd_req_n", {31'd0, req}, 32'd0);
      tick();
      idle_inputs();
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd_req_n1", {31'd0, req}, 32'd1);
      chk("rd_req_addr", req_addr, 32'h0000_1000);
      chk("rd_req_size", {30'd0, req_size}, 32'd2);
      chk("rd_wr", {31'd0, wr}, 32'd0);
      chk("rd_stall_n1", {31'd0, stall}, 32'd1);
      tick();
      idle_inputs();
      #1;
      chk("rd_stall_n2", {31'd0, stall}, 32'd0);
      chk("rd_req_n2", {31'd0, req}, 32'd0);
      chk("rd_data_r", data_r, 32'hDEAD_BEEF);

      // Hold in DONE with stray data_ok that must be ignored
      for (int i = 0; i < 5; i++) begin
         tick();
         data_ok = 1'b1; rdata = 32'h1111_0000 + i;
         #1;
         chk("hold_data_r", data_r, 32'hDEAD_BEEF);
         chk("hold_req", {31'd0, req}, 32'd0);
         chk("hold_stall", {31'd0, stall}, 32'd0);
      end
      tick();
      idle_inputs();
      update = 1'b1;
      tick();
      idle_inputs();
      #1;
      chk("idle_stall", {31'd0, stall}, 32'd0);

      // Split handshake: addr_ok at N+3, data_ok at N+6
      tick();
      en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_3000;
      #1;
      chk("split_stall_n", {31'd0, stall}, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         idle_inputs();
         addr_ok = (k == 3);
         data_ok = (k == 6);
         rdata = 32'hCAFE_F00D;
         #1;
         chk("split_req", {31'd0, req}, (k <= 3) ? 32'd1 : 32'd0);
         chk("split_stall", {31'd0, stall}, 32'd1);
      end
      tick();
      idle_inputs();
      #1;
      chk("split_stall_n7", {31'd0, stall}, 32'd0);
      chk("split_data_r", data_r, 32'hCAFE_F00D);

      // Back-to-back write then read of 0x2000
      update = 1'b1; en = 1'b1; we = 1'b1; size = 2'b10;
      addr = 32'h0000_2000; data_w = 32'h1234_5678;
      #1;
      chk("b2b_done_stall", {31'd0, stall}, 32'd0);
      tick();
      idle_inputs();
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hBAD0_BAD0;
      #1;
      chk("wr_req", {31'd0, req}, 32'd1);
      chk("wr_wr", {31'd0, wr}, 32'd1);
      chk("wr_wdata", req_wdata, 32'h1234_5678);
      chk("wr_addr", req_addr, 32'h0000_2000);
      tick();
      idle_inputs();
      update = 1'b1; en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_2000;
      #1;
      chk("wr_data_r_kept", data_r, 32'hCAFE_F00D);
      chk("wr_done_stall", {31'd0, stall}, 32'd0);
      tick();
      idle_inputs();
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
      #1;
      chk("rb_wr", {31'd0, wr}, 32'd0);
      chk("rb_req", {31'd0, req}, 32'd1);
      tick();
      idle_inputs();
      update = 1'b1;
      #1;
      chk("rb_data_r", data_r, 32'h1234_5678);

      // data_ok in IDLE is ignored
      tick();
      idle_inputs();
      data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
      tick();
      idle_inputs();
      #1;
      chk("idle_dok_data_r", data_r, 32'h1234_5678);
      chk("idle_dok_req", {31'd0, req}, 32'd0);

      // Reset in the middle of a DATA phase
      tick();
      en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_4000;
      tick();
      idle_inputs();
      addr_ok = 1'b1;
      tick();
      idle_inputs();
      #1;
      chk("mid_data_req", {31'd0, req}, 32'd0);
      chk("mid_data_stall", {31'd0, stall}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      chk("mid_rst_req", {31'd0, req}, 32'd0);
      chk("mid_rst_data_r", data_r, 32'h0);
      chk("mid_rst_req_addr", req_addr, 32'h0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         data_ok = 1'b1; rdata = 32'h5555_5555;
         #1;
         chk("late_dok_data_r", data_r, 32'h0);
         chk("late_dok_stall", {31'd0, stall}, 32'd0);
      end
      tick();
      idle_inputs();

      // Misaligned word read at 0x1002
      tick();
      en = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_1002;
      tick();
      idle_inputs();
      #1;
`ifdef SBUS_BRIDGE_ALIGN_CHECK_EN
      chk("mis_req", {31'd0, req}, 32'd0);
      chk("mis_flag", {31'd0, misalign}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      chk("mis_data_r", data_r, 32'h0);
`else
      chk("mis_req", {31'd0, req}, 32'd1);
      chk("mis_req_addr", req_addr, 32'h0000_1002);
      chk("mis_flag", {31'd0, misalign}, 32'd0);
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hA5A5_0102;
      tick();
      idle_inputs();
      #1;
      chk("mis_data_r", data_r, 32'hA5A5_0102);
      chk("mis_stall", {31'd0, stall}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sbus_bridge.md
SBUS_BRIDGE -- requirements
Module: sbus_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: width of addr/req_addr.
REQ-002 Parameter DATA_W, default 32: width of data_w, data_r, req_wdata, rdata.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (low = reset).
REQ-005 en  input  1  sbus request valid from pipeline.
REQ-006 we  input  1  sbus write enable.
REQ-007 size  input  2  access size: 00 byte, 01 half, 10 word.
REQ-008 addr  input  ADDR_W  sbus byte address.
REQ-009 data_w  input  DATA_W  sbus write data.
REQ-010 update  input  1  pipeline consumed current result; may issue next request.
REQ-011 data_r  output  DATA_W  read data of last completed access.
REQ-012 stall  output  1  pipeline must hold; access outstanding.
REQ-013 req  output  1  downstream request valid.
REQ-014 wr, req_size, req_addr, req_wdata  output  1/2/ADDR_W/DATA_W  registered copies of we/size/addr/data_w.
REQ-015 addr_ok  input  1  downstream accepted address.
REQ-016 data_ok  input  1  downstream completed data phase.
REQ-017 rdata  input  DATA_W  downstream read data, valid with data_ok.
REQ-018 misalign  output  1  misaligned-access flag (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-020 IDLE: en=1 captures we/size/addr/data_w into request registers, next state ADDR; else stay.
REQ-021 ADDR: req=1; addr_ok&data_ok -> DONE; addr_ok only -> DATA; else stay with req and request registers stable.
REQ-022 DATA: req=0; data_ok -> DONE; else stay.
REQ-023 On data_ok with wr=0, rdata SHALL be registered into data_r; writes leave data_r unchanged.
REQ-024 DONE: data_r held; update&en -> capture new request, ADDR (back-to-back); update&!en -> IDLE; !update -> stay.
REQ-025 stall = (state==IDLE & en) | state==ADDR | state==DATA; stall=0 in DONE and in IDLE with en=0.
REQ-026 Minimum latency: en at cycle N, req at N+1, addr_ok&data_ok at N+1 -> stall low at N+2.
REQ-027 data_ok arriving in IDLE or DONE SHALL be ignored (no state change, data_r unchanged).
REQ-028 Exactly one request outstanding at any time; req never asserted outside ADDR.

Reset
REQ-029 rst low SHALL immediately force state IDLE, req=0, stall=0, misalign=0, data_r=0, request registers=0, including mid-access.
REQ-030 After rst rises, the first en SHALL be treated as a fresh IDLE request; a downstream response from a pre-reset access SHALL be ignored.

Configuration
REQ-031 Macro SBUS_BRIDGE_ALIGN_CHECK_EN defined: in IDLE/DONE capture, size=10 with addr[1:0]!=0 or size=01 with addr[0]=1 SHALL NOT enter ADDR; instead state DONE, misalign=1 for that DONE residency, data_r unchanged, req never asserted.
REQ-032 Macro undefined: no check, all requests forwarded, misalign tied 0.

Verification
REQ-033 Read: en=1,we=0,size=10,addr=0x1000 at N; addr_ok&data_ok, rdata=0xDEADBEEF at N+1 -> req_addr=0x1000 at N+1, stall low at N+2, data_r=0xDEADBEEF.
REQ-034 Split handshake: addr_ok at N+3, data_ok at N+6 -> req high N+1..N+3, stall high N..N+6, low N+7.
REQ-035 Write then read back-to-back: write 0x12345678 to 0x2000, update&en (read 0x2000) in DONE -> wr=1,req_wdata=0x12345678 then wr=0; data_r updated only by read.
REQ-036 Reset mid-access: rst low in DATA -> req=0, stall=0 same cycle; late data_ok after release ignored, data_r=0.
REQ-037 With SBUS_BRIDGE_ALIGN_CHECK_EN: word read at 0x1002 -> req stays 0, misalign=1, stall low at N+1; without macro -> req_addr=0x1002 issued.
REQ-038 Hold: DONE with update=0 for 5 cycles -> data_r stable, no req, stall=0.
